// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: func3 codes, FSM states
// and the access-legality check used on both load and store paths.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Misalignment or a func3 that is not legal for this direction.
    function automatic logic is_access_error(input logic       is_write,
                                             input logic [2:0] f3,
                                             input logic [1:0] byte_off);
        logic err;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = byte_off[0];
            F3_W:    err = (byte_off != 2'b00);
            F3_BU:   err = is_write;
            F3_HU:   err = is_write | byte_off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM with per-byte write strobes: synchronous write,
// asynchronous read. Contents have no reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_memory_controller.sv
// Memory-access stage controller: fixed-latency byte/half/word loads and stores
// against dmem_array, with a combinational stall and registered load result.
module data_memory_controller
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        busy,
    output logic        access_error,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic SINGLE = (LATENCY == 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_count;
    logic [AW+1:0] r_addr;
    logic [2:0]    r_func3;
    logic [31:0]   r_wdata;
    logic          r_is_write;
    logic [31:0]   r_read_data;
    logic          r_access_error;

    logic          w_req;
    logic          w_last;
    logic          w_perform;
    logic [AW+1:0] w_op_addr;
    logic [2:0]    w_op_func3;
    logic [31:0]   w_op_wdata;
    logic          w_op_write;
    logic          w_op_err;
    logic [3:0]    w_be;
    logic [31:0]   w_lane_wdata;
    logic          w_we;
    logic [31:0]   w_rdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ext;
    logic [31:0]   w_load_result;
    logic          w_unused_addr;

    assign w_unused_addr = ^address[31:AW+2];
    assign w_req  = mem_read | mem_write;
    assign w_last = (r_count <= CW'(1));
    assign w_perform = ((r_state == ACCESS) && w_last)
                     || (SINGLE && (r_state == IDLE) && w_req);

    // In IDLE the live request is the operation source (LATENCY=1 completes
    // in the request cycle); otherwise the latched copy is used.
    assign w_op_addr  = (r_state == IDLE) ? address[AW+1:0] : r_addr;
    assign w_op_func3 = (r_state == IDLE) ? func3           : r_func3;
    assign w_op_wdata = (r_state == IDLE) ? write_data      : r_wdata;
    assign w_op_write = (r_state == IDLE) ? mem_write       : r_is_write;
    assign w_op_err   = is_access_error(w_op_write, w_op_func3, w_op_addr[1:0]);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next_state = SINGLE ? DONE : ACCESS;
            ACCESS:  if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = RESET & (((r_state == IDLE) & w_req) | (r_state == ACCESS));
        dbg_state = r_state;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_count    <= '0;
            r_addr     <= '0;
            r_func3    <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_count    <= SINGLE ? '0 : CNT_LOAD;
                r_addr     <= address[AW+1:0];
                r_func3    <= func3;
                r_wdata    <= write_data;
                r_is_write <= mem_write;
            end else if (r_state == ACCESS) begin
                r_count <= r_count - CW'(1);
            end else begin
                r_count <= '0;
            end
        end
    end

    always_comb begin
        w_be         = 4'b0000;
        w_lane_wdata = w_op_wdata;
        case (w_op_func3[1:0])
            2'b00: begin
                w_be         = 4'b0001 << w_op_addr[1:0];
                w_lane_wdata = {4{w_op_wdata[7:0]}};
            end
            2'b01: begin
                w_be         = w_op_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{w_op_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // RESET gate keeps an access aborted by reset from touching the array.
    assign w_we = w_perform & w_op_write & ~w_op_err & RESET;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .i_clk  (CLK),
        .i_we   (w_we),
        .i_be   (w_be),
        .i_addr (w_op_addr[AW+1:2]),
        .i_wdata(w_lane_wdata),
        .o_rdata(w_rdata)
    );

    always_comb begin
        w_byte = w_rdata[7:0];
        case (w_op_addr[1:0])
            2'b00: w_byte = w_rdata[7:0];
            2'b01: w_byte = w_rdata[15:8];
            2'b10: w_byte = w_rdata[23:16];
            2'b11: w_byte = w_rdata[31:24];
            default: w_byte = w_rdata[7:0];
        endcase
        w_half = w_op_addr[1] ? w_rdata[31:16] : w_rdata[15:0];
        case (w_op_func3)
            F3_B:    w_ext = {{24{w_byte[7]}}, w_byte};
            F3_H:    w_ext = {{16{w_half[15]}}, w_half};
            F3_W:    w_ext = w_rdata;
            F3_BU:   w_ext = {24'd0, w_byte};
            F3_HU:   w_ext = {16'd0, w_half};
            default: w_ext = 32'd0;
        endcase
        w_load_result = (w_op_write | w_op_err) ? 32'd0 : w_ext;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_read_data    <= 32'd0;
            r_access_error <= 1'b0;
        end else if (w_perform) begin
            r_read_data    <= w_load_result;
            r_access_error <= w_op_err;
        end
    end

    assign read_data    = r_read_data;
    assign access_error = r_access_error;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller: a vector table of loads/stores
// with hand-computed results, plus reset-abort and start-up sequences.
module tb_data_memory_controller;

    localparam int LAT = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic        CLK;
    logic        RESET;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        busy;
    logic        access_error;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t tbl[$];

    data_memory_controller #(
        .DEPTH_WORDS(256),
        .LATENCY    (LAT)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .func3       (func3),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .busy        (busy),
        .access_error(access_error),
        .dbg_state   (dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, input string name);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.exp_data = ed; v.exp_err = ee; v.name = name;
        tbl.push_back(v);
    endtask

    // Request held through DONE, dropped one edge later as EX/MA advances.
    task automatic run_access(input vec_t v);
        int n;
        bit done_seen;
        n = 0;
        done_seen = 0;
        @(posedge CLK);
        #1;
        mem_read = v.rd; mem_write = v.wr; func3 = v.f3;
        address = v.addr; write_data = v.wdata;
        for (int g = 0; g < 20; g++) begin
            @(negedge CLK);
            if (!busy) begin
                done_seen = 1;
                break;
            end
            n++;
        end
        if (!done_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: busy still high after 20 cycles", v.name);
        end
        check({v.name, "_busy_cycles"}, 32'(n), 32'(LAT));
        check({v.name, "_state_done"}, 32'(dbg_state), 32'(ST_DONE));
        check({v.name, "_data"}, read_data, v.exp_data);
        check({v.name, "_err"}, 32'(access_error), 32'(v.exp_err));
        @(posedge CLK);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge CLK);
        check({v.name, "_idle_after"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check({v.name, "_no_stall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t v;
        RESET = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        func3 = 3'b000; address = 32'd0; write_data = 32'd0;

        //  rd wr f3      addr          wdata          exp_data       err
        add(0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0, "sw_10");
        add(1, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, "lw_10");
        add(0, 1, 3'b000, 32'h11,  32'h0000007F, 32'h0,        0, "sb_11");
        add(1, 0, 3'b010, 32'h10,  32'h0,        32'hDEAD7FEF, 0, "lw_10_after_sb");
        add(1, 0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 0, "lb_13");
        add(1, 0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 0, "lbu_13");
        add(1, 0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 0, "lh_12");
        add(1, 0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 0, "lhu_12");
        add(1, 0, 3'b010, 32'h12,  32'h0,        32'h0,        1, "lw_misaligned");
        add(1, 0, 3'b010, 32'h10,  32'h0,        32'hDEAD7FEF, 0, "lw_after_err");
        add(1, 0, 3'b000, 32'h11,  32'h0,        32'h0000007F, 0, "lb_11_pos");
        add(1, 0, 3'b001, 32'h10,  32'h0,        32'h00007FEF, 0, "lh_10_pos");
        add(0, 1, 3'b001, 32'h13,  32'h00001234, 32'h0,        1, "sh_misaligned");
        add(0, 1, 3'b011, 32'h10,  32'h00000000, 32'h0,        1, "store_bad_f3");
        add(1, 0, 3'b010, 32'h10,  32'h0,        32'hDEAD7FEF, 0, "lw_unchanged");
        add(1, 0, 3'b110, 32'h10,  32'h0,        32'h0,        1, "load_bad_f3");
        add(0, 1, 3'b001, 32'h12,  32'hFFFF8001, 32'h0,        0, "sh_12");
        add(1, 0, 3'b010, 32'h410, 32'h0,        32'h80017FEF, 0, "lw_wrap");
        add(1, 1, 3'b010, 32'h30,  32'hA5A5A5A5, 32'h0,        0, "rw_both");
        add(1, 0, 3'b010, 32'h30,  32'h0,        32'hA5A5A5A5, 0, "lw_30");
        add(0, 1, 3'b010, 32'h20,  32'h11112222, 32'h0,        0, "sw_20");
        add(0, 1, 3'b000, 32'h23,  32'h000000AB, 32'h0,        0, "sb_23");
        add(1, 0, 3'b010, 32'h20,  32'h0,        32'hAB112222, 0, "lw_20");

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_data", read_data, 32'd0);
        check("reset_err", 32'(access_error), 32'd0);
        RESET = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_access(tbl[i]);
        end

        // Store aborted by reset mid-ACCESS must leave memory unchanged.
        @(posedge CLK);
        #1;
        mem_write = 1'b1; func3 = 3'b010; address = 32'h20; write_data = 32'h12345678;
        @(negedge CLK);
        check("abort_req_busy", 32'(busy), 32'd1);
        @(negedge CLK);
        check("abort_in_access", {30'd0, dbg_state}, {30'd0, ST_ACCESS});
        RESET = 1'b0;
        mem_write = 1'b0;
        #1;
        check("abort_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", read_data, 32'd0);
        check("abort_err", 32'(access_error), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        v.rd = 1; v.wr = 0; v.f3 = 3'b010; v.addr = 32'h20; v.wdata = 32'h0;
        v.exp_data = 32'hAB112222; v.exp_err = 0; v.name = "lw_20_after_abort";
        run_access(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_controller.md
# data_memory_controller

Data-memory controller for the memory-access stage of the RV32IM pipeline. It consumes the request from the EX/MA pipeline register (read/write enables, func3, ALU address, rs2 data) and performs byte, halfword and word loads and stores against a word-organised RAM with a fixed multi-cycle latency. It returns sign- or zero-extended load data to the MA/WB register. It raises `busy` to stall all upstream pipeline registers while an access is in flight.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words; must be a power of two.
- `LATENCY`, 2: cycles `busy` stays high per access; minimum 1.

Ports:
- `CLK`  in  1  pipeline clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  load request from EX/MA.
- `mem_write`  in  1  store request from EX/MA.
- `func3`  in  3  RV32 load/store width and sign code.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (rs2).
- `read_data`  out  32  extended load result, registered.
- `busy`  out  1  stall request to IF/ID, ID/EX, EX/MA, MA/WB and the PC.
- `access_error`  out  1  misaligned access or illegal func3, registered.

## Operation
- Word index is `address[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the memory size.
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: down-counter running.
  - DONE: one cycle; inputs are ignored here.
- IDLE → ACCESS when `mem_read | mem_write`. The counter loads `LATENCY-1`. The request is latched: address, func3, data, read or write.
- When `mem_read` and `mem_write` are both high, the write wins and the read is dropped.
- ACCESS decrements the counter each cycle. At count 0 it performs the latched operation and moves to DONE.
- With `LATENCY`=1, IDLE → DONE directly and the operation is performed at that edge.
- DONE → IDLE unconditionally. The still-held request is not re-triggered.
- Store codes:
  - 000 SB: writes byte lane `address[1:0]` with `write_data[7:0]`.
  - 001 SH: writes halfword lane `address[1]` with `write_data[15:0]`.
  - 010 SW: writes the full word.
- Load codes:
  - 000 LB and 001 LH: sign-extend.
  - 100 LBU and 101 LHU: zero-extend.
  - 010 LW: full word.
- Error conditions:
  - A halfword access with `address[0]`=1 is an error.
  - A word access with `address[1:0]`≠0 is an error.
  - Load func3 011, 110 or 111 is an error.
  - Store func3 other than 000, 001 or 010 is an error.
  - On error: memory is unchanged, `read_data`=0, `access_error`=1, and the access still takes `LATENCY` cycles.
- `read_data` and `access_error` are updated only on DONE entry and hold until the next DONE entry.
- A store completes with `read_data` set to 0.
- `RESET` low forces IDLE, counter 0, `busy`=0, `read_data`=0 and `access_error`=0. RAM contents are preserved.
- A reset asserted mid-access aborts the access. A store aborted before its final ACCESS edge leaves memory unchanged.

## Timing
- `busy` = (IDLE & (`mem_read` | `mem_write`)) | ACCESS. It is combinational, so the pipeline stalls in the request cycle itself.
- `busy` is high for exactly `LATENCY` consecutive cycles per access and is low in DONE.
- Load data is valid in the DONE cycle. MA/WB captures it at the end of DONE, which is also when EX/MA advances to the next instruction.
- Back-to-back accesses cost `LATENCY`+1 cycles each.
- Non-memory instructions pass with zero stall.

## Structure
- Package `dmem_pkg`:
  - func3 constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - state enum: IDLE, ACCESS, DONE.
- Sub-module `dmem_array`: single-port word RAM with 4-bit byte-write strobe, synchronous write and asynchronous read.
- The controller contains:
  - the FSM;
  - the counter;
  - the request latch;
  - the lane/strobe generation;
  - the load extension logic.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 → `busy` high 2 cycles each, then `read_data`=0xDEADBEEF in DONE.
- SB with data 0x7F to 0x11, then LW 0x10 → 0xDEAD7FEF.
- LB 0x13 → 0xFFFFFFDE.
- LBU 0x13 → 0x000000DE.
- LH 0x12 → 0xFFFFDEAD.
- LHU 0x12 → 0x0000DEAD.
- LW 0x12 → `access_error`=1, `read_data`=0; a following LW 0x10 still returns 0xDEAD7FEF.
- SW 0x12345678 to 0x20 with `RESET` pulsed low during ACCESS → outputs 0 and FSM IDLE; LW 0x20 afterwards returns the old contents.
- Request held high through DONE, then `mem_read` and `mem_write` both high to 0x30 with data 0xA5A5A5A5:
  - held request → exactly one access;
  - both high → store occurs, then LW 0x30 = 0xA5A5A5A5.
